// File: rtl/door_plant_model.sv
// rtl/door_plant_model.sv - motorized door plant with end-of-travel sensors
// Closes the loop around the door controller and flags motor conflicts and end-stop overruns.
module door_plant_model #(
  parameter int TRAVEL_CYCLES  = 16,
  parameter int POS_WIDTH      = 8,
  parameter int OVERRUN_CYCLES = 4,
  parameter bit INIT_OPEN      = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Up_M,
  input  logic                 Dn_M,
  input  logic                 Obstruct,
  output logic                 Up_Max,
  output logic                 Dn_Max,
  output logic [POS_WIDTH-1:0] Position,
  output logic [1:0]           Dir,
  output logic [1:0]           Fault
);

  localparam int OVR_W = (OVERRUN_CYCLES < 1) ? 1 : $clog2(OVERRUN_CYCLES + 1);
  localparam logic [POS_WIDTH-1:0] TRAVEL_MAX = POS_WIDTH'(TRAVEL_CYCLES);
  localparam logic [OVR_W-1:0]     OVR_MAX    = OVR_W'(OVERRUN_CYCLES);
  localparam logic [POS_WIDTH-1:0] POS_RESET  = INIT_OPEN ? TRAVEL_MAX : '0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [POS_WIDTH-1:0] r_pos, w_pos_nxt;
  logic [OVR_W-1:0]     r_ovr, w_ovr_nxt;
  logic [1:0]           r_fault, w_fault_nxt;
  logic                 w_up_only, w_dn_only, w_conflict, w_push;
  logic                 w_at_top, w_at_bot;

  assign w_at_top   = (r_pos == TRAVEL_MAX);
  assign w_at_bot   = (r_pos == '0);
  assign w_up_only  = Up_M & ~Dn_M;
  assign w_dn_only  = Dn_M & ~Up_M;
  assign w_conflict = Up_M & Dn_M;
  // Obstruct is deliberately absent: a blocked motor pushing into a stop still overruns.
  assign w_push     = (w_up_only & w_at_top) | (w_dn_only & w_at_bot);

  assign Up_Max   = w_at_top;
  assign Dn_Max   = w_at_bot;
  assign Position = r_pos;
  assign Fault    = r_fault;
  assign Dir      = (r_state == RISE) ? 2'b01 :
                    (r_state == FALL) ? 2'b10 : 2'b00;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_pos   <= POS_RESET;
      r_ovr   <= '0;
      r_fault <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_ovr   <= w_ovr_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_ovr_nxt   = r_ovr;
    w_fault_nxt = r_fault;

    if (w_conflict) begin
      w_fault_nxt[0] = 1'b1;
    end

    // HALT freezes everything except the conflict flag above.
    if (r_state != HALT) begin
      if (!w_push) begin
        w_ovr_nxt = '0;
      end else if (r_ovr != OVR_MAX) begin
        w_ovr_nxt = r_ovr + 1'b1;
      end

      if (w_ovr_nxt == OVR_MAX) begin
        w_fault_nxt[1] = 1'b1;
      end

      if (w_conflict || (w_ovr_nxt == OVR_MAX)) begin
        w_state_nxt = HALT;
      end else if (w_up_only && !Obstruct && !w_at_top) begin
        w_pos_nxt   = r_pos + 1'b1;
        w_state_nxt = RISE;
      end else if (w_dn_only && !Obstruct && !w_at_bot) begin
        w_pos_nxt   = r_pos - 1'b1;
        w_state_nxt = FALL;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_door_plant_model.sv
// tb/tb_door_plant_model.sv - self-checking bench for door_plant_model
module tb_door_plant_model;

  localparam int TRAVEL = 16;
  localparam int PW     = 8;
  localparam int OVR    = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Up_M, Dn_M, Obstruct;
  logic          Up_Max, Dn_Max;
  logic [PW-1:0] Position;
  logic [1:0]    Dir, Fault;

  door_plant_model #(
    .TRAVEL_CYCLES (TRAVEL),
    .POS_WIDTH     (PW),
    .OVERRUN_CYCLES(OVR),
    .INIT_OPEN     (1'b0)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Up_M    (Up_M),
    .Dn_M    (Dn_M),
    .Obstruct(Obstruct),
    .Up_Max  (Up_Max),
    .Dn_Max  (Dn_Max),
    .Position(Position),
    .Dir     (Dir),
    .Fault   (Fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       up;
    logic       dn;
    logic       obs;
    int         pos;
    logic [1:0] dir;
    logic [1:0] fault;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic up, input logic dn, input logic obs,
                              input int pos, input logic [1:0] dir, input logic [1:0] fault);
    vec_t v;
    v.up = up; v.dn = dn; v.obs = obs; v.pos = pos; v.dir = dir; v.fault = fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    chk({tag, " Position"}, 32'(Position), e.pos);
    chk({tag, " Dir"},      32'(Dir),      32'(e.dir));
    chk({tag, " Fault"},    32'(Fault),    32'(e.fault));
    chk({tag, " Up_Max"},   32'(Up_Max),   32'(e.pos == TRAVEL));
    chk({tag, " Dn_Max"},   32'(Dn_Max),   32'(e.pos == 0));
  endtask

  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(negedge CLK);
    Up_M = v.up; Dn_M = v.dn; Obstruct = v.obs;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e);
    end
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("%s[%0d]", tag, i), vecs[i]);
    end
    vecs.delete();
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1; Up_M = 1'b0; Dn_M = 1'b0; Obstruct = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_outputs(tag, mk(0, 0, 0, 0, 2'b00, 2'b00));
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic rise_to(input int n);
    for (int i = 1; i <= n; i++) vecs.push_back(mk(1, 0, 0, i, 2'b01, 2'b00));
  endtask

  initial begin
    do_reset("reset");

    // Full travel, overrun at the open stop, then HALT ignores Dn_M.
    rise_to(TRAVEL);
    for (int i = 1; i <= OVR; i++)
      vecs.push_back(mk(1, 0, 0, TRAVEL, 2'b00, (i == OVR) ? 2'b10 : 2'b00));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, TRAVEL, 2'b00, 2'b10));
    run_vecs("travel");

    // Conflict at mid travel latches HALT.
    do_reset("reset2");
    rise_to(8);
    vecs.push_back(mk(1, 1, 0, 8, 2'b00, 2'b01));
    vecs.push_back(mk(1, 0, 0, 8, 2'b00, 2'b01));
    vecs.push_back(mk(0, 1, 0, 8, 2'b00, 2'b01));
    vecs.push_back(mk(0, 0, 0, 8, 2'b00, 2'b01));
    run_vecs("conflict");

    // Obstruct holds the door, then release; reversal both ways.
    do_reset("reset3");
    rise_to(8);
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 1, 8, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 7, 2'b10, 2'b00));
    vecs.push_back(mk(1, 0, 0, 8, 2'b01, 2'b00));
    vecs.push_back(mk(0, 1, 0, 7, 2'b10, 2'b00));
    vecs.push_back(mk(0, 0, 0, 7, 2'b00, 2'b00));
    run_vecs("obstruct");

    // Interrupted push into the closed stop restarts the count; obstruct does not clear it.
    do_reset("reset4");
    for (int i = 0; i < OVR - 1; i++) vecs.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00));
    for (int i = 0; i < OVR - 1; i++) vecs.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0, 2'b00, 2'b10));
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 2'b10));
    vecs.push_back(mk(1, 1, 0, 0, 2'b00, 2'b11));
    run_vecs("overrun_closed");

    // Asynchronous reset in the middle of a rise.
    do_reset("reset5");
    rise_to(5);
    run_vecs("midrst_rise");
    #2;
    RST = 1'b1; Up_M = 1'b0;
    #1;
    check_outputs("midrst_async", mk(0, 0, 0, 0, 2'b00, 2'b00));
    @(negedge CLK);
    RST = 1'b0;
    step("midrst_after", mk(1, 0, 0, 1, 2'b01, 2'b00));
    step("midrst_after2", mk(1, 0, 0, 2, 2'b01, 2'b00));

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/door_plant_model.md
# door_plant_model

Synthesizable model of the motorized door and its end-of-travel sensors, closing the loop around the door controller. It consumes the Up/Down motor commands and produces the Up_Max/Dn_Max limit-sensor signals from an internal door-position counter. It also flags illegal motor usage: both motors on, or driving into an end stop. It sits opposite the controller in simulation and FPGA self-test builds, replacing the physical door.

## Interface
- TRAVEL_CYCLES, 16: clock cycles of motor drive for a full close-to-open travel; ≥ 2.
- POS_WIDTH, 8: width of the position counter; must satisfy 2^POS_WIDTH > TRAVEL_CYCLES.
- OVERRUN_CYCLES, 4: consecutive cycles of motor drive into an active end stop before an overrun fault latches; ≥ 1.
- INIT_OPEN, 0: reset position. 0 = fully closed, 1 = fully open.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- Up_M  in  1  up-motor command from controller.
- Dn_M  in  1  down-motor command from controller.
- Obstruct  in  1  test stimulus; while high, the door cannot move.
- Up_Max  out  1  door fully open: Position == TRAVEL_CYCLES.
- Dn_Max  out  1  door fully closed: Position == 0.
- Position  out  POS_WIDTH  current door position, 0..TRAVEL_CYCLES.
- Dir  out  2  motion in the last cycle: 00 still, 01 rose, 10 fell.
- Fault  out  2  sticky flags: bit0 motor conflict, bit1 end-stop overrun.

## Operation
- State machine with states IDLE, RISE, FALL and HALT. Dir encodes the state (IDLE/HALT → 00).
- Per rising edge, not in HALT:
  - Up_M=1, Dn_M=0, Obstruct=0, Position<TRAVEL_CYCLES → Position+1, state RISE.
  - Dn_M=1, Up_M=0, Obstruct=0, Position>0 → Position−1, state FALL.
  - Otherwise → Position holds, state IDLE.
- Up_M=1 and Dn_M=1 in the same cycle → Fault[0] set, state HALT, Position holds.
- Overrun counter:
  - Increments each cycle in which Up_M=1, Dn_M=0 with Up_Max=1.
  - Also increments each cycle in which Dn_M=1, Up_M=0 with Dn_Max=1.
  - Clears on any other cycle.
  - When the counter reaches OVERRUN_CYCLES → Fault[1] set, state HALT. The counter saturates.
- HALT is terminal until RST.
  - Position frozen, Dir=00.
  - Fault bits remain set, and further conflicts can still set Fault[0].
- Position never leaves 0..TRAVEL_CYCLES. There is no wrap-around.
- Obstruct does not clear the overrun counter. Obstruct while away from an end stop never causes overrun.
- Up_Max and Dn_Max are combinational decodes of the registered Position. They are glitch-free and are never both high, since TRAVEL_CYCLES ≥ 2.
- Reset values:
  - Position = INIT_OPEN ? TRAVEL_CYCLES : 0.
  - Up_Max = INIT_OPEN, Dn_Max = !INIT_OPEN.
  - Dir = 00, Fault = 00, overrun counter = 0, state IDLE.

## Timing
- Motor command to position change: 1 cycle. Up_M sampled at edge N → Position updated after edge N.
- Up_Max/Dn_Max change in the same cycle as Position. No extra latency.
- Full travel: TRAVEL_CYCLES consecutive edges with Up_M=1. Up_Max rises after the TRAVEL_CYCLES-th edge; Dn_Max falls after the 1st edge.
- Overrun: Fault[1] rises after the OVERRUN_CYCLES-th consecutive edge that samples motor-into-stop.
- Conflict: Fault[0] rises after the first edge that samples Up_M=Dn_M=1.
- RST asserted mid-travel: all outputs take reset values immediately and asynchronously. On the first edge after RST deasserts, inputs are sampled normally.
- Motor reversal (Up_M→Dn_M without an idle cycle) is legal. Position changes direction on the next edge, and Dir goes 01→10.

## Test plan
- Reset (INIT_OPEN=0) → Position=0, Dn_Max=1, Up_Max=0, Dir=00, Fault=00.
- Up_M=1 for 16 edges (TRAVEL_CYCLES=16) → Position steps 1..16, Dir=01. Dn_Max=0 after edge 1; Up_Max=1 after edge 16.
- From open, Up_M held 4 more edges (OVERRUN_CYCLES=4) → Fault=10 after the 4th, Dir=00. Then Dn_M=1 → Position stays 16 (HALT).
- Position 8, Up_M=Dn_M=1 for one edge → Fault=01, Position stays 8, all later commands ignored until RST.
- Position 8, Dn_M=1 with Obstruct=1 for 10 edges → Position 8, Dir=00, Fault=00. Drop Obstruct → Position 7 after the next edge.
- Position 5 rising, assert RST mid-cycle → Position=0, Dn_Max=1 immediately. Release RST, Up_M=1 → Position=1 after the next edge.
